// File: rtl/sample_envelope_if.sv
// Sample stream into and envelope stream out of the envelope follower.
// The slave side is the follower itself; the master side is whoever feeds
// samples and consumes the envelope (the audio source / word clipper pair).
interface sample_envelope_if;
    logic        ivalid;
    logic [15:0] idata;
    logic        ilast;
    logic        ovalid;
    logic [31:0] oidx;
    logic [15:0] odata;
    logic        olast;

    modport slave (
        input  ivalid, idata, ilast,
        output ovalid, oidx, odata, olast
    );

    modport master (
        output ivalid, idata, ilast,
        input  ovalid, oidx, odata, olast
    );
endinterface

// File: rtl/sample_envelope.sv
// Envelope follower: rectifies signed PCM samples and emits a moving average
// of |x| over a 2^LOG2_WIN window, tagged with a per-utterance sample index.
// Two register stages: rectify/tag, then window update and output register.
module sample_envelope #(
    parameter int LOG2_WIN = 4
) (
    input  logic              iclk,
    input  logic              irstn,
    sample_envelope_if.slave  s
);
    localparam int WIN  = 1 << LOG2_WIN;
    localparam int SUMW = 15 + LOG2_WIN;
    localparam logic [LOG2_WIN:0]   FILL_FULL = (LOG2_WIN + 1)'(WIN);
    localparam logic [LOG2_WIN:0]   FILL_ONE  = (LOG2_WIN + 1)'(1);
    localparam logic [LOG2_WIN-1:0] WPTR_ONE  = LOG2_WIN'(1);

    // stage 1
    logic        s1_valid_q;
    logic [14:0] s1_abs_q;
    logic [31:0] s1_idx_q;
    logic        s1_last_q;
    logic [31:0] idx_cnt_q;
    logic [14:0] abs_d;

    // stage 2 / window state
    logic [SUMW-1:0]     sum_q;
    logic [SUMW-1:0]     sum_d;
    logic [SUMW-1:0]     oldest_d;
    logic [LOG2_WIN:0]   fill_q;
    logic [LOG2_WIN-1:0] wptr_q;
    logic [14:0]         win_q [WIN];

    logic        ovalid_q;
    logic [31:0] oidx_q;
    logic [15:0] odata_q;
    logic        olast_q;

    // Rectify with saturation; -32768 has no positive 16-bit counterpart.
    // For every other negative value the low 15 bits of the negation are |x|.
    always_comb begin
        abs_d = s.idata[14:0];
        if (s.idata[15]) begin
            if (s.idata[14:0] == 15'd0) begin
                abs_d = 15'h7FFF;
            end else begin
                abs_d = (~s.idata[14:0]) + 15'd1;
            end
        end
    end

    // Stage 1: capture rectified sample with its index; index restarts after ilast.
    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            s1_valid_q <= 1'b0;
            s1_abs_q   <= '0;
            s1_idx_q   <= '0;
            s1_last_q  <= 1'b0;
            idx_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s.ivalid;
            if (s.ivalid) begin
                s1_abs_q  <= abs_d;
                s1_idx_q  <= idx_cnt_q;
                s1_last_q <= s.ilast;
                idx_cnt_q <= s.ilast ? 32'd0 : idx_cnt_q + 32'd1;
            end
        end
    end

    // Running sum: evict the oldest sample only once the window is full, so
    // the fill phase ramps up as if missing samples were zero.
    always_comb begin
        oldest_d = '0;
        if (fill_q == FILL_FULL) begin
            oldest_d = {{LOG2_WIN{1'b0}}, win_q[wptr_q]};
        end
        sum_d = sum_q - oldest_d + {{LOG2_WIN{1'b0}}, s1_abs_q};
    end

    // Window buffer holds no reset; stale contents are masked by fill_q.
    always_ff @(posedge iclk) begin
        if (s1_valid_q) begin
            win_q[wptr_q] <= s1_abs_q;
        end
    end

    // Stage 2: update window state, register outputs; a last sample wipes the
    // window after use so the next sample starts fresh with no bubble.
    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            sum_q    <= '0;
            fill_q   <= '0;
            wptr_q   <= '0;
            ovalid_q <= 1'b0;
            oidx_q   <= '0;
            odata_q  <= '0;
            olast_q  <= 1'b0;
        end else begin
            ovalid_q <= s1_valid_q;
            if (s1_valid_q) begin
                odata_q <= {1'b0, sum_d[SUMW-1:LOG2_WIN]};
                oidx_q  <= s1_idx_q;
                olast_q <= s1_last_q;
                if (s1_last_q) begin
                    sum_q  <= '0;
                    fill_q <= '0;
                    wptr_q <= '0;
                end else begin
                    sum_q  <= sum_d;
                    wptr_q <= wptr_q + WPTR_ONE;
                    if (fill_q != FILL_FULL) begin
                        fill_q <= fill_q + FILL_ONE;
                    end
                end
            end
        end
    end

    assign s.ovalid = ovalid_q;
    assign s.oidx   = oidx_q;
    assign s.odata  = odata_q;
    assign s.olast  = olast_q;
endmodule

// File: tb/tb_sample_envelope.sv
// Directed bench for the envelope follower: a vector table checked two cycles
// after each input, plus a hand-written asynchronous reset sequence.
module tb_sample_envelope;
    logic iclk = 1'b0;
    logic irstn = 1'b0;
    always #5 iclk = ~iclk;

    sample_envelope_if bus ();
    sample_envelope #(.LOG2_WIN(4)) dut (.iclk(iclk), .irstn(irstn), .s(bus));

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        l;
        logic [31:0] eidx;
        logic [15:0] edata;
        logic        elast;
        logic        chk;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] bidx;
    int          n_pass;
    int          n_total;

    function automatic void add(logic [15:0] d, logic l, logic [15:0] edata, logic chk);
        vec_t r;
        r.v = 1'b1; r.d = d; r.l = l; r.eidx = bidx;
        r.edata = edata; r.elast = l; r.chk = chk;
        vecs.push_back(r);
        bidx = l ? 32'd0 : bidx + 32'd1;
    endfunction

    function automatic void add_gap();
        vec_t r;
        r.v = 1'b0; r.d = 16'd0; r.l = 1'b0; r.eidx = 32'd0;
        r.edata = 16'd0; r.elast = 1'b0; r.chk = 1'b0;
        vecs.push_back(r);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    int   e1 [20] = '{6, 12, 18, 25, 31, 37, 43, 50, 56, 62,
                      68, 75, 81, 87, 93, 100, 100, 100, 100, 100};
    vec_t e;

    initial begin
        n_pass = 0; n_total = 0; bidx = 32'd0;
        bus.ivalid = 1'b0; bus.idata = 16'd0; bus.ilast = 1'b0;

        // ramp of +100, ends utterance
        for (int i = 0; i < 20; i++) add(16'd100, i == 19, 16'(e1[i]), 1'b1);
        // saturation of -32768 then -1000
        for (int i = 0; i < 16; i++) add(16'h8000, 1'b0, 16'd32767, i == 15);
        add(16'hFC18, 1'b1, 16'd30781, 1'b1);
        // fill with 1000 then drain with 0s
        for (int i = 0; i < 32; i++) begin
            logic [15:0] x;
            logic        c;
            x = (i < 16) ? 16'd1000 : 16'd0;
            c = (i == 15) || (i == 16) || (i == 20) || (i == 31);
            add(x, i == 31, (i == 15) ? 16'd1000 : (i == 16) ? 16'd937 :
                            (i == 20) ? 16'd687 : 16'd0, c);
        end
        // alternating +-200 with gaps between samples
        for (int i = 0; i < 40; i++) begin
            add((i % 2 == 1) ? 16'hFF38 : 16'd200, i == 39, 16'd200, i >= 15);
            add_gap();
        end
        // short utterance then back-to-back new one
        for (int i = 0; i < 5; i++) add(16'd500, i == 4, 16'd156, i == 4);
        add(16'd100, 1'b1, 16'd6, 1'b1);

        #1;
        check("rst_ovalid", {31'd0, bus.ovalid}, 32'd0);
        check("rst_oidx",   bus.oidx, 32'd0);
        check("rst_odata",  {16'd0, bus.odata}, 32'd0);
        check("rst_olast",  {31'd0, bus.olast}, 32'd0);
        @(negedge iclk);
        irstn = 1'b1;

        for (int k = 0; k < vecs.size() + 2; k++) begin
            @(negedge iclk);
            if (k >= 2) begin
                e = vecs[k-2];
                if (e.v) begin
                    check($sformatf("ovalid[%0d]", k-2), {31'd0, bus.ovalid}, 32'd1);
                    check($sformatf("oidx[%0d]", k-2), bus.oidx, e.eidx);
                    check($sformatf("olast[%0d]", k-2), {31'd0, bus.olast}, {31'd0, e.elast});
                    if (e.chk)
                        check($sformatf("odata[%0d] idx %0d", k-2, e.eidx),
                              {16'd0, bus.odata}, {16'd0, e.edata});
                end else begin
                    check($sformatf("gap_ovalid[%0d]", k-2), {31'd0, bus.ovalid}, 32'd0);
                end
            end
            if (k < vecs.size()) begin
                bus.ivalid = vecs[k].v; bus.idata = vecs[k].d; bus.ilast = vecs[k].l;
            end else begin
                bus.ivalid = 1'b0; bus.idata = 16'd0; bus.ilast = 1'b0;
            end
        end

        // asynchronous reset with samples in flight
        for (int k = 0; k < 4; k++) begin
            @(negedge iclk);
            bus.ivalid = 1'b1; bus.idata = 16'd100; bus.ilast = 1'b0;
        end
        check("pre_rst_ovalid", {31'd0, bus.ovalid}, 32'd1);
        check("pre_rst_oidx",   bus.oidx, 32'd1);
        check("pre_rst_odata",  {16'd0, bus.odata}, 32'd12);
        #1;
        irstn = 1'b0;
        bus.ivalid = 1'b0; bus.idata = 16'd0;
        #1;
        check("arst_ovalid", {31'd0, bus.ovalid}, 32'd0);
        check("arst_oidx",   bus.oidx, 32'd0);
        check("arst_odata",  {16'd0, bus.odata}, 32'd0);
        check("arst_olast",  {31'd0, bus.olast}, 32'd0);
        #1;
        irstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge iclk);
            check("post_rst_no_ovalid", {31'd0, bus.ovalid}, 32'd0);
        end
        bus.ivalid = 1'b1; bus.idata = 16'd100; bus.ilast = 1'b1;
        @(negedge iclk);
        bus.ivalid = 1'b0; bus.idata = 16'd0; bus.ilast = 1'b0;
        @(negedge iclk);
        check("post_rst_ovalid", {31'd0, bus.ovalid}, 32'd1);
        check("post_rst_oidx",   bus.oidx, 32'd0);
        check("post_rst_odata",  {16'd0, bus.odata}, 32'd6);
        check("post_rst_olast",  {31'd0, bus.olast}, 32'd1);
        @(negedge iclk);
        check("post_rst_single_pulse", {31'd0, bus.ovalid}, 32'd0);
        check("post_rst_hold_odata",   {16'd0, bus.odata}, 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
